// File: rtl/audio_sched_pkg.sv
// Shared constants, state encoding and bit-index helper for the audio frame scheduler.
// The fractional clock-enable generator also takes its defaults from here.
package audio_sched_pkg;

    localparam int FRAC_NUM    = 12;
    localparam int FRAC_DEN    = 125;
    localparam int BITS_PER_CH = 24;
    localparam int NUM_CH      = 2;
    localparam int FRAME_BITS  = BITS_PER_CH * NUM_CH;
    localparam int ACC_W       = 8;
    localparam int IDX_W       = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } sched_state_t;

    // Next bit position within a frame, wrapping from frame_len-1 back to 0.
    function automatic logic [IDX_W-1:0] next_bit_idx(input logic [IDX_W-1:0] idx,
                                                      input int              frame_len);
        logic [IDX_W-1:0] result;
        if (idx == IDX_W'(frame_len - 1)) begin
            result = '0;
        end else begin
            result = idx + IDX_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/frac_tick_gen.sv
// Fractional-N clock-enable generator: emits NUM enables per DEN clocks,
// spread as evenly as the integer grid allows.
module frac_tick_gen #(
    parameter int NUM   = audio_sched_pkg::FRAC_NUM,
    parameter int DEN   = audio_sched_pkg::FRAC_DEN,
    parameter int ACC_W = audio_sched_pkg::ACC_W
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic half_tick
);

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W:0]   sum;
    logic             wrap;

    // One extra bit so acc+NUM cannot overflow before the modulus compare.
    assign sum  = {1'b0, acc_reg} + (ACC_W+1)'(NUM);
    assign wrap = (sum >= (ACC_W+1)'(DEN));

    always_comb begin
        acc_next  = '0;
        half_tick = 1'b0;
        if (en) begin
            half_tick = wrap;
            if (wrap) begin
                acc_next = ACC_W'(sum - (ACC_W+1)'(DEN));
            end else begin
                acc_next = sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

endmodule

// File: rtl/audio_frame_sched.sv
// Audio bit clock / frame sequencer: derives bclk, ws, per-bit strobes and frame
// requests from the oscillator clock using a fractional half-tick enable.
module audio_frame_sched #(
    parameter int NUM         = audio_sched_pkg::FRAC_NUM,
    parameter int DEN         = audio_sched_pkg::FRAC_DEN,
    parameter int BITS_PER_CH = audio_sched_pkg::BITS_PER_CH,
    parameter int NUM_CH      = audio_sched_pkg::NUM_CH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    output logic       bclk,
    output logic       ws,
    output logic       bit_shift,
    output logic       bit_sample,
    output logic [5:0] bit_idx,
    output logic       frame_start,
    output logic       sample_req,
    output logic       running
);
    import audio_sched_pkg::*;

    localparam int               FRAME_LEN = BITS_PER_CH * NUM_CH;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] RIGHT_IDX = IDX_W'(BITS_PER_CH);

    sched_state_t     state_reg, state_next;
    logic             bclk_reg, bclk_next;
    logic             ws_reg, ws_next;
    logic             bit_shift_reg, bit_shift_next;
    logic             bit_sample_reg, bit_sample_next;
    logic [IDX_W-1:0] bit_idx_reg, bit_idx_next;
    logic             frame_start_reg, frame_start_next;
    logic             sample_req_reg, sample_req_next;
    logic             running_reg, running_next;

    logic             half_tick;
    logic             tick_en;
    logic             at_wrap;
    logic             resume;
    logic [IDX_W-1:0] idx_inc;

    assign tick_en = (state_reg != IDLE);
    assign at_wrap = (bit_idx_reg == LAST_IDX);
    assign idx_inc = next_bit_idx(bit_idx_reg, FRAME_LEN);
    assign resume  = (state_reg == STOPPING) && start && !stop;

    frac_tick_gen #(
        .NUM   (NUM),
        .DEN   (DEN),
        .ACC_W (ACC_W)
    ) u_tick (
        .clk       (clk),
        .reset     (reset),
        .en        (tick_en),
        .half_tick (half_tick)
    );

    always_comb begin
        state_next       = state_reg;
        bclk_next        = bclk_reg;
        ws_next          = ws_reg;
        bit_idx_next     = bit_idx_reg;
        bit_shift_next   = 1'b0;
        bit_sample_next  = 1'b0;
        frame_start_next = 1'b0;
        sample_req_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                bclk_next    = 1'b0;
                ws_next      = 1'b0;
                bit_idx_next = '0;
                if (start && !stop) begin
                    state_next       = RUN;
                    frame_start_next = 1'b1;
                    sample_req_next  = 1'b1;
                end
            end

            RUN, STOPPING: begin
                if (state_reg == RUN && stop) begin
                    state_next = STOPPING;
                end else if (resume) begin
                    state_next = RUN;
                end

                if (half_tick) begin
                    if (!bclk_reg) begin
                        bclk_next       = 1'b1;
                        bit_sample_next = 1'b1;
                    end else begin
                        bclk_next      = 1'b0;
                        bit_shift_next = 1'b1;
                        bit_idx_next   = idx_inc;
                        ws_next        = (idx_inc >= RIGHT_IDX);
                        // A pending stop completes here unless start just rescinded it.
                        if (at_wrap) begin
                            if (state_reg == STOPPING && !resume) begin
                                state_next = IDLE;
                            end else begin
                                frame_start_next = 1'b1;
                                sample_req_next  = 1'b1;
                            end
                        end
                    end
                end
            end

            default: begin
                state_next   = IDLE;
                bclk_next    = 1'b0;
                ws_next      = 1'b0;
                bit_idx_next = '0;
            end
        endcase

        running_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            bclk_reg        <= 1'b0;
            ws_reg          <= 1'b0;
            bit_shift_reg   <= 1'b0;
            bit_sample_reg  <= 1'b0;
            bit_idx_reg     <= '0;
            frame_start_reg <= 1'b0;
            sample_req_reg  <= 1'b0;
            running_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bclk_reg        <= bclk_next;
            ws_reg          <= ws_next;
            bit_shift_reg   <= bit_shift_next;
            bit_sample_reg  <= bit_sample_next;
            bit_idx_reg     <= bit_idx_next;
            frame_start_reg <= frame_start_next;
            sample_req_reg  <= sample_req_next;
            running_reg     <= running_next;
        end
    end

    assign bclk        = bclk_reg;
    assign ws          = ws_reg;
    assign bit_shift   = bit_shift_reg;
    assign bit_sample  = bit_sample_reg;
    assign bit_idx     = bit_idx_reg;
    assign frame_start = frame_start_reg;
    assign sample_req  = sample_req_reg;
    assign running     = running_reg;

endmodule
